// File: rtl/lm32_dp_ram_ext.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and an after-reset zero-fill sequencer.
module lm32_dp_ram_ext #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned addr_depth = 1024,
    parameter int unsigned data_width = 32,
    parameter int unsigned byte_width = 8,
    parameter int unsigned rdw_mode   = 0,
    parameter int unsigned out_reg    = 0,
    parameter int unsigned init_clear = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               we_i,
    input  logic [data_width/byte_width-1:0]   be_i,
    input  logic [addr_width-1:0]              waddr_i,
    input  logic [data_width-1:0]              wdata_i,
    input  logic                               re_i,
    input  logic [addr_width-1:0]              raddr_i,
    output logic [data_width-1:0]              rdata_o,
    output logic                               rvalid_o,
    output logic                               busy_o
);

    localparam int unsigned NB = data_width / byte_width;
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(addr_depth - 1);
    localparam logic [addr_width:0]   DEPTH     = (addr_width + 1)'(addr_depth);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [addr_width-1:0]  clr_cnt;
    logic [data_width-1:0]  mem [addr_depth];

    logic                   wr_en;
    logic                   rd_en;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic [data_width-1:0]  rd_word;

    // Clear sequencer: one zero word per cycle, then hand over to normal operation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= (init_clear != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            busy_o  <= (init_clear != 0);
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state  <= ST_RUN;
                busy_o <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + addr_width'(1);
            end
        end
    end

    assign wr_in_range = {1'b0, waddr_i} < DEPTH;
    assign rd_in_range = {1'b0, raddr_i} < DEPTH;
    assign wr_en       = (state == ST_RUN) && we_i && wr_in_range && !rst_i;
    assign rd_en       = (state == ST_RUN) && re_i;

    // Array has no reset so contents survive reset when clearing is disabled
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_i[k]) begin
                        mem[waddr_i][k*byte_width +: byte_width] <= wdata_i[k*byte_width +: byte_width];
                    end
                end
            end
        end
    end

    // Read word with optional per-lane forwarding of a same-edge write
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[raddr_i];
        end
        if ((rdw_mode == 1) && wr_en && (waddr_i == raddr_i)) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) begin
                    rd_word[k*byte_width +: byte_width] = wdata_i[k*byte_width +: byte_width];
                end
            end
        end
    end

    generate
        if (out_reg != 0) begin : g_oreg
            logic                  s1_vld;
            logic [data_width-1:0] s1_data;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s1_vld   <= 1'b0;
                    s1_data  <= '0;
                    rvalid_o <= 1'b0;
                    rdata_o  <= '0;
                end else begin
                    s1_vld   <= rd_en;
                    rvalid_o <= s1_vld;
                    if (rd_en) begin
                        s1_data <= rd_word;
                    end
                    if (s1_vld) begin
                        rdata_o <= s1_data;
                    end
                end
            end
        end else begin : g_noreg
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rvalid_o <= 1'b0;
                    rdata_o  <= '0;
                end else begin
                    rvalid_o <= rd_en;
                    if (rd_en) begin
                        rdata_o <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_lm32_dp_ram_ext.sv
// Directed bench driving three RAM configurations from shared stimulus:
// A = depth16/new-data/no out reg, B = depth12/old-data/out reg, C = no clear.
module tb_lm32_dp_ram_ext;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;

    lm32_dp_ram_ext #(
        .addr_width(4), .addr_depth(16), .data_width(32), .byte_width(8),
        .rdw_mode(1), .out_reg(0), .init_clear(1)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
        .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata_a), .rvalid_o(rvalid_a), .busy_o(busy_a)
    );

    lm32_dp_ram_ext #(
        .addr_width(4), .addr_depth(12), .data_width(32), .byte_width(8),
        .rdw_mode(0), .out_reg(1), .init_clear(1)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
        .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata_b), .rvalid_o(rvalid_b), .busy_o(busy_b)
    );

    lm32_dp_ram_ext #(
        .addr_width(4), .addr_depth(16), .data_width(32), .byte_width(8),
        .rdw_mode(0), .out_reg(0), .init_clear(0)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
        .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata_c), .rvalid_o(rvalid_c), .busy_o(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sv(input int i);
        return 32'hC0DE_0000 | (32'(i) * 32'h111);
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; waddr = a; wdata = d; be = b;
        cyc();
        we = 1'b0; be = 4'h0;
    endtask

    // Single read: A and C answer after one edge, B after two
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [31:0] ec, input bit use_c);
        re = 1'b1; raddr = a;
        cyc();
        re = 1'b0;
        chk({tag, "_vld_a"}, 32'(rvalid_a), 32'd1);
        chk({tag, "_dat_a"}, rdata_a, ea);
        chk({tag, "_b_early"}, 32'(rvalid_b), 32'd0);
        if (use_c) chk({tag, "_dat_c"}, rdata_c, ec);
        cyc();
        chk({tag, "_pulse_a"}, 32'(rvalid_a), 32'd0);
        chk({tag, "_vld_b"}, 32'(rvalid_b), 32'd1);
        chk({tag, "_dat_b"}, rdata_b, eb);
    endtask

    // Counts busy cycles from reset release; requests present on entry are dropped after 8 cycles
    task automatic clr_wait(output int ca, output int cb, output bit rv);
        ca = 0; cb = 0; rv = 1'b0;
        rst = 1'b0;
        if (busy_a) ca++;
        if (busy_b) cb++;
        for (int i = 0; i < 40; i++) begin
            if (i == 8) begin
                we = 1'b0; re = 1'b0; be = 4'h0;
            end
            cyc();
            if (rvalid_a || rvalid_b) rv = 1'b1;
            if (!busy_a && !busy_b) break;
            if (busy_a) ca++;
            if (busy_b) cb++;
        end
    endtask

    int ca, cb;
    bit rv;

    initial begin
        rst = 1'b1; we = 1'b0; be = 4'h0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
        repeat (3) cyc();
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_busy_c", 32'(busy_c), 32'd0);

        // Requests issued while clearing must be ignored by A and B, honoured by C
        we = 1'b1; be = 4'hF; waddr = 4'd0; wdata = 32'h1234_5678; re = 1'b1; raddr = 4'd2;
        clr_wait(ca, cb, rv);
        chk("clr_len_a", 32'(ca), 32'd16);
        chk("clr_len_b", 32'(cb), 32'd12);
        chk("clr_no_rvalid", 32'(rv), 32'd0);
        chk("clr_busy_c", 32'(busy_c), 32'd0);

        rd_chk("rd0", 4'd0, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
        rd_chk("rd5", 4'd5, 32'h0, 32'h0, 32'h0, 1'b0);

        wr(4'd3, 32'hAABB_CCDD, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'h5);
        rd_chk("be", 4'd3, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44, 1'b1);

        wr(4'd7, 32'h0, 4'hF);
        we = 1'b1; waddr = 4'd7; wdata = 32'hFFFF_FFFF; be = 4'h3; re = 1'b1; raddr = 4'd7;
        cyc();
        we = 1'b0; be = 4'h0; re = 1'b0;
        chk("rdw_new_a", rdata_a, 32'h0000_FFFF);
        chk("rdw_old_c", rdata_c, 32'h0);
        cyc();
        chk("rdw_old_b", rdata_b, 32'h0);
        rd_chk("rdw_after", 4'd7, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);

        for (int i = 0; i < 8; i++) wr(4'(i), sv(i), 4'hF);
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; raddr = 4'(i);
            cyc();
            chk("strm_vld_a", 32'(rvalid_a), 32'd1);
            chk("strm_dat_a", rdata_a, sv(i));
            chk("strm_dat_c", rdata_c, sv(i));
            if (i > 0) begin
                chk("strm_vld_b", 32'(rvalid_b), 32'd1);
                chk("strm_dat_b", rdata_b, sv(i - 1));
            end
        end
        re = 1'b0;
        cyc();
        chk("strm_end_a", 32'(rvalid_a), 32'd0);
        chk("strm_hold_a", rdata_a, sv(7));
        chk("strm_last_vld_b", 32'(rvalid_b), 32'd1);
        chk("strm_last_dat_b", rdata_b, sv(7));
        cyc();
        chk("strm_end_b", 32'(rvalid_b), 32'd0);
        chk("strm_hold_b", rdata_b, sv(7));

        wr(4'd13, 32'hDEAD_BEEF, 4'hF);
        rd_chk("oor13", 4'd13, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1);
        rd_chk("oor_alias1", 4'd1, sv(1), sv(1), sv(1), 1'b1);

        wr(4'd2, 32'hFFFF_FFFF, 4'h0);
        rd_chk("be_zero", 4'd2, sv(2), sv(2), sv(2), 1'b1);

        // Reset with reads in flight, then reset again mid-clear
        re = 1'b1; raddr = 4'd3;
        cyc();
        re = 1'b0;
        rst = 1'b1;
        #1;
        chk("rrd_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rrd_rdata_a", rdata_a, 32'h0);
        chk("rrd_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rrd_rdata_b", rdata_b, 32'h0);
        cyc();
        rst = 1'b0;
        rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rvalid_a || rvalid_b) rv = 1'b1;
        end
        chk("rrd_no_rvalid", 32'(rv), 32'd0);
        chk("mid_busy_a", 32'(busy_a), 32'd1);
        rst = 1'b1;
        cyc();
        clr_wait(ca, cb, rv);
        chk("reclr_len_a", 32'(ca), 32'd16);
        chk("reclr_len_b", 32'(cb), 32'd12);
        chk("reclr_no_rvalid", 32'(rv), 32'd0);

        rd_chk("persist3", 4'd3, 32'h0, 32'h0, sv(3), 1'b1);
        rd_chk("persist13", 4'd13, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
